// File: rtl/counter_pkg.sv
// Shared constants and types for the parameterised up/down counter.
// Holds the boundary-mode encodings, the default width and the per-edge operation type.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Boundary behaviour when counting past 0 or MAX
  localparam int unsigned SAT_WRAP = 0;
  localparam int unsigned SAT_SAT  = 1;

  // Operation selected on each clock edge, highest priority first
  typedef enum logic [1:0] {
    OpClear,
    OpLoad,
    OpCount,
    OpHold
  } op_e;

endpackage

// File: rtl/counter_next.sv
// Combinational step for the up/down counter: next value and boundary detection.
// The wrapped value is always produced here; saturation is decided by the caller.
module counter_next #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             up,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] nxt,
  output logic             bnd
);

  logic at_top;
  logic at_bottom;

  assign at_top    = (cnt == max);
  assign at_bottom = (cnt == '0);

  always_comb begin
    nxt = cnt;
    bnd = 1'b0;
    if (up) begin
      bnd = at_top;
      nxt = at_top ? '0 : cnt + WIDTH'(1);
    end else begin
      bnd = at_bottom;
      nxt = at_bottom ? max : cnt - WIDTH'(1);
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with clear, clamped parallel load, wrap or saturate at
// the 0..MAX boundaries, a one-cycle wrap pulse and a sticky overflow flag.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH = DEFAULT_WIDTH,
  parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     SAT   = SAT_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ena,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "param_updown_counter: WIDTH must be in 2..32");
  end

  if (MAX < 64'd1 || MAX >= (64'd1 << WIDTH)) begin : g_bad_max
    $fatal(1, "param_updown_counter: MAX must satisfy 1 <= MAX < 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxVal = MAX[WIDTH-1:0];

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_cnt;
  logic             at_bnd;
  logic [WIDTH-1:0] load_val;
  op_e              op;

  counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .cnt(cnt_q),
    .up (up),
    .max(MaxVal),
    .nxt(step_cnt),
    .bnd(at_bnd)
  );

  // Out-of-range load data clamps to MAX so the count never leaves 0..MAX
  assign load_val = (data > MaxVal) ? MaxVal : data;

  always_comb begin
    op = OpHold;
    if (clr) begin
      op = OpClear;
    end else if (ena && load) begin
      op = OpLoad;
    end else if (ena) begin
      op = OpCount;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    unique case (op)
      OpClear: begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      OpLoad: begin
        cnt_d = load_val;
      end
      OpCount: begin
        if (!at_bnd) begin
          cnt_d = step_cnt;
        end else begin
          ovf_d = 1'b1;
          if (SAT != SAT_SAT) begin
            cnt_d  = step_cnt;
            wrap_d = 1'b1;
          end
        end
      end
      OpHold: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;
  assign tc   = ena & at_bnd;

endmodule
